// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter slice.
package rtc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  // Idle levels for the active-low strobes {ad, wr, rd, cs} and the AD drive value.
  localparam logic [3:0] BUS_IDLE_CTRL = 4'b1111;
  localparam logic [7:0] BUS_IDLE_DATA = 8'h00;

  localparam logic MST_RD = 1'b0;
  localparam logic MST_WR = 1'b1;

  // One master's (or the pad side's) complete bus drive.
  typedef struct packed {
    logic       ad;
    logic       wr;
    logic       rd;
    logic       cs;
    logic [7:0] dout;
    logic       oe;
  } bus_t;

  // Bus value presented to the RTC while nobody owns it: strobes high, AD not driven.
  function automatic bus_t bus_idle();
    bus_t v;
    {v.ad, v.wr, v.rd, v.cs} = BUS_IDLE_CTRL;
    v.dout                   = BUS_IDLE_DATA;
    v.oe                     = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh timer: counts 0..REFRESH_CYCLES-1 and pulses tick on the
// terminal count, one cycle per period.
module rtc_refresh_timer #(
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Period counter, wraps at the terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == C_LAST);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbiter for the shared RTC address/data bus between the periodic reader
// (master 0) and the configuration writer (master 1), with idle gaps between
// owners and a registered output mux.
// Optional feature macro: RTC_ARB_TIMEOUT_EN (grant-duration timeout with
// forced release and a timeout_err pulse; TIMEOUT_CYCLES exists only then).
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 4
`ifdef RTC_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  output logic       wr_gnt,
  input  logic       wr_done,
  output logic       rd_gnt,
  input  logic       rd_done,
  output logic       refresh_start,
  input  logic       m0_ad,
  input  logic       m0_wr,
  input  logic       m0_rd,
  input  logic       m0_cs,
  input  logic [7:0] m0_dout,
  input  logic       m0_oe,
  input  logic       m1_ad,
  input  logic       m1_wr,
  input  logic       m1_rd,
  input  logic       m1_cs,
  input  logic [7:0] m1_dout,
  input  logic       m1_oe,
  output logic       bus_ad,
  output logic       bus_wr,
  output logic       bus_rd,
  output logic       bus_cs,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic       busy,
  output logic       timeout_err
);

  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_CYCLES - 1);

  arb_state_e    r_state;
  arb_state_e    w_next_state;
  logic          r_refresh_pend;
  logic          r_last_owner;
  logic [GW-1:0] r_gap_cnt;
  logic          r_wr_gnt;
  logic          r_rd_gnt;
  logic          r_refresh_start;
  logic          r_busy;
  logic          r_timeout_err;
  bus_t          r_bus;
  bus_t          w_bus_next;
  bus_t          w_m0;
  bus_t          w_m1;
  logic          w_tick;
  logic          w_to_hit;
  logic          w_timeout;
  logic          w_enter_rd;
  logic          w_enter_wr;

  assign w_m0 = {m0_ad, m0_wr, m0_rd, m0_cs, m0_dout, m0_oe};
  assign w_m1 = {m1_ad, m1_wr, m1_rd, m1_cs, m1_dout, m1_oe};

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (w_tick)
  );

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;

  // Cycles spent in the current grant; zero on the grant entry edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == GNT_RD) || (r_state == GNT_WR)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_to_hit = (r_to_cnt == C_TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, release on done or timeout, gap countdown.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_refresh_pend && wr_req) begin
          w_next_state = (r_last_owner == MST_WR) ? GNT_RD : GNT_WR;
        end else if (r_refresh_pend) begin
          w_next_state = GNT_RD;
        end else if (wr_req) begin
          w_next_state = GNT_WR;
        end else begin
          w_next_state = IDLE;
        end
      end
      GNT_RD: begin
        if (rd_done) begin
          w_next_state = GAP;
        end else if (w_to_hit) begin
          w_next_state = GAP;
          w_timeout    = 1'b1;
        end else begin
          w_next_state = GNT_RD;
        end
      end
      GNT_WR: begin
        if (wr_done) begin
          w_next_state = GAP;
        end else if (w_to_hit) begin
          w_next_state = GAP;
          w_timeout    = 1'b1;
        end else begin
          w_next_state = GNT_WR;
        end
      end
      GAP: begin
        if (r_gap_cnt == C_GAP_LAST) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GAP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_enter_rd = (r_state == IDLE) && (w_next_state == GNT_RD);
  assign w_enter_wr = (r_state == IDLE) && (w_next_state == GNT_WR);

  // Bus source follows the state being entered, so the bus is idle from the release edge.
  always_comb begin
    w_bus_next = bus_idle();
    case (w_next_state)
      GNT_RD:  w_bus_next = w_m0;
      GNT_WR:  w_bus_next = w_m1;
      default: w_bus_next = bus_idle();
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Gap length counter, zero on GAP entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gap_cnt <= '0;
    end else if (r_state == GAP) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Pending refresh request: the sweep starting now absorbs a coincident tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_refresh_pend <= 1'b0;
    end else if (w_enter_rd) begin
      r_refresh_pend <= 1'b0;
    end else if (w_tick) begin
      r_refresh_pend <= 1'b1;
    end else begin
      r_refresh_pend <= r_refresh_pend;
    end
  end

  // Remember who was granted last so contention alternates between masters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_owner <= MST_RD;
    end else if (w_enter_rd) begin
      r_last_owner <= MST_RD;
    end else if (w_enter_wr) begin
      r_last_owner <= MST_WR;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  // Registered status outputs and bus drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_gnt        <= 1'b0;
      r_wr_gnt        <= 1'b0;
      r_refresh_start <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_bus           <= bus_idle();
    end else begin
      r_rd_gnt        <= (w_next_state == GNT_RD);
      r_wr_gnt        <= (w_next_state == GNT_WR);
      r_refresh_start <= w_enter_rd;
      r_busy          <= (w_next_state != IDLE);
      r_timeout_err   <= w_timeout;
      r_bus           <= w_bus_next;
    end
  end

  assign rd_gnt        = r_rd_gnt;
  assign wr_gnt        = r_wr_gnt;
  assign refresh_start = r_refresh_start;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;
  assign bus_ad        = r_bus.ad;
  assign bus_wr        = r_bus.wr;
  assign bus_rd        = r_bus.rd;
  assign bus_cs        = r_bus.cs;
  assign bus_dout      = r_bus.dout;
  assign bus_oe        = r_bus.oe;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of ownership, gaps and refresh scheduling.
module tb_rtc_bus_arbiter;

  localparam int N = 100;
  localparam int G = 4;
  localparam int T = 16;
`ifdef RTC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
  logic       m0_ad = 1'b1, m0_wr = 1'b1, m0_rd = 1'b1, m0_cs = 1'b1, m0_oe = 1'b0;
  logic [7:0] m0_dout = 8'h00;
  logic       m1_ad = 1'b1, m1_wr = 1'b1, m1_rd = 1'b1, m1_cs = 1'b1, m1_oe = 1'b0;
  logic [7:0] m1_dout = 8'h00;
  logic       wr_gnt, rd_gnt, refresh_start, busy, timeout_err;
  logic       bus_ad, bus_wr, bus_rd, bus_cs, bus_oe;
  logic [7:0] bus_dout;

  rtc_bus_arbiter #(
    .REFRESH_CYCLES(N),
    .GAP_CYCLES(G)
`ifdef RTC_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(T)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .rd_gnt(rd_gnt), .rd_done(rd_done), .refresh_start(refresh_start),
    .m0_ad(m0_ad), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_cs(m0_cs), .m0_dout(m0_dout), .m0_oe(m0_oe),
    .m1_ad(m1_ad), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_cs(m1_cs), .m1_dout(m1_dout), .m1_oe(m1_oe),
    .bus_ad(bus_ad), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_cs(bus_cs),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // edges since reset was released

  // Transaction-level model: who owns the bus, how much idle gap is left,
  // whether a sweep is owed, who went last, how long the grant has run.
  int          m_owner = 0;   // 0 none, 1 reader, 2 writer
  int          m_gap   = 0;
  bit          m_pend  = 1'b0;
  int          m_last  = 1;
  int          m_age   = 0;
  int          m_edges = 0;
  logic [17:0] m_exp   = {5'b00000, 4'hF, 8'h00, 1'b0};

  task automatic model_edge();
    bit tick, start, err, done;
    logic [12:0] busv;
    if (reset) begin
      m_owner = 0; m_gap = 0; m_pend = 1'b0; m_last = 1; m_age = 0; m_edges = 0;
      m_exp = {5'b00000, 4'hF, 8'h00, 1'b0};
      return;
    end
    tick    = ((m_edges % N) == N - 1);
    m_edges = m_edges + 1;
    start   = 1'b0;
    err     = 1'b0;
    if (m_owner == 0 && m_gap == 0) begin
      if (m_pend && wr_req)  m_owner = (m_last == 2) ? 1 : 2;
      else if (m_pend)       m_owner = 1;
      else if (wr_req)       m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner;
        m_age  = 0;
        start  = (m_owner == 1);
      end
    end else if (m_owner != 0) begin
      done = (m_owner == 1) ? rd_done : wr_done;
      if (done) begin
        m_owner = 0; m_gap = G;
      end else if (TO_EN && m_age == T - 1) begin
        m_owner = 0; m_gap = G; err = 1'b1;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      m_gap = m_gap - 1;
    end
    if (start)     m_pend = 1'b0;
    else if (tick) m_pend = 1'b1;
    if (m_owner == 1)      busv = {m0_ad, m0_wr, m0_rd, m0_cs, m0_dout, m0_oe};
    else if (m_owner == 2) busv = {m1_ad, m1_wr, m1_rd, m1_cs, m1_dout, m1_oe};
    else                   busv = {4'hF, 8'h00, 1'b0};
    m_exp = {(m_owner == 2), (m_owner == 1), start, (m_owner != 0 || m_gap > 0), err, busv};
  endtask

  // One clock: model follows the sampled inputs, then the whole output set is compared.
  task automatic step();
    logic [17:0] act;
    @(posedge clock);
    model_edge();
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
    #1;
    act = {wr_gnt, rd_gnt, refresh_start, busy, timeout_err,
           bus_ad, bus_wr, bus_rd, bus_cs, bus_dout, bus_oe};
    total = total + 1;
    if (act !== m_exp) begin
      bad = bad + 1;
      $display("FAIL model cyc=%0d got=%05h want=%05h", cyc, act, m_exp);
    end
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1; step(); rd_done = 1'b0;
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1; step(); wr_done = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (3) step();
    check_lit("rst_gnt",  {6'd0, rd_gnt, wr_gnt}, 8'h00);
    check_lit("rst_busy", {6'd0, busy, refresh_start}, 8'h00);
    check_lit("rst_ctrl", {4'd0, bus_ad, bus_wr, bus_rd, bus_cs}, 8'h0F);
    check_lit("rst_data", bus_dout, 8'h00);
    check_lit("rst_oe",   {7'd0, bus_oe}, 8'h00);
    reset = 1'b0;

    // First refresh sweep, stray done pulses, reader bus drive.
    run_to(100);
    check_lit("no_start_100", {7'd0, refresh_start}, 8'h00);
    run_to(101);
    check_lit("start_101", {7'd0, refresh_start}, 8'h01);
    check_lit("rdgnt_101", {7'd0, rd_gnt}, 8'h01);
    step();
    check_lit("start_pulse", {7'd0, refresh_start}, 8'h00);
    m0_dout = 8'h5A; m0_oe = 1'b1; m0_cs = 1'b0; m1_dout = 8'hC3; m1_oe = 1'b0;
    step();
    check_lit("m0_dout", bus_dout, 8'h5A);
    check_lit("m0_ctrl", {4'd0, bus_ad, bus_wr, bus_rd, bus_cs, bus_oe}, 8'h1D);
    run_to(119);
    pulse_wr_done();
    check_lit("wrdone_ignored", {6'd0, rd_gnt, busy}, 8'h03);
    run_to(150);
    pulse_rd_done();
    check_lit("rdgnt_low_151", {7'd0, rd_gnt}, 8'h00);
    check_lit("bus_idle_151", {3'd0, bus_ad, bus_wr, bus_rd, bus_cs, bus_oe}, 8'h1E);
    run_to(154);
    check_lit("busy_154", {7'd0, busy}, 8'h01);
    step();
    check_lit("busy_155", {7'd0, busy}, 8'h00);
    run_to(159);
    pulse_rd_done();
    check_lit("stray_rddone", {5'd0, busy, rd_gnt, wr_gnt}, 8'h00);

    // Contention: writer wins over the pending sweep, then the reader gets its turn.
    run_to(200);
    wr_req = 1'b1;
    step();
    check_lit("wr_first", {6'd0, wr_gnt, rd_gnt}, 8'h02);
    m1_dout = 8'h26; m1_oe = 1'b1; m0_dout = 8'hFF;
    step();
    check_lit("m1_dout", bus_dout, 8'h26);
    check_lit("m1_oe", {7'd0, bus_oe}, 8'h01);
    m0_dout = 8'h11; m0_oe = 1'b0;
    step();
    check_lit("m0_hidden", bus_dout, 8'h26);
    run_to(209);
    pulse_wr_done();
    check_lit("wrgnt_low", {7'd0, wr_gnt}, 8'h00);
    run_to(214);
    check_lit("idle_214", {7'd0, busy}, 8'h00);
    step();
    check_lit("rd_after_wr", {5'd0, refresh_start, wr_gnt, rd_gnt}, 8'h05);
    run_to(219);
    pulse_rd_done();
    run_to(225);
    check_lit("wr_again", {7'd0, wr_gnt}, 8'h01);
    wr_req = 1'b0;
    step();
    check_lit("wr_hold_noreq", {7'd0, wr_gnt}, 8'h01);

    // Grant with no done: forced release, or an indefinite hold.
    if (TO_EN) begin
      run_to(240);
      check_lit("to_before", {6'd0, wr_gnt, timeout_err}, 8'h02);
      step();
      check_lit("to_pulse", {6'd0, wr_gnt, timeout_err}, 8'h01);
      check_lit("to_bus_oe", {7'd0, bus_oe}, 8'h00);
      step();
      check_lit("to_once", {7'd0, timeout_err}, 8'h00);
    end else begin
      run_to(260);
      check_lit("hold_forever", {6'd0, wr_gnt, timeout_err}, 8'h02);
      pulse_wr_done();
    end

    // Reset in the 5th cycle of a reader grant.
    run_to(301);
    check_lit("rd_301", {7'd0, rd_gnt}, 8'h01);
    m0_oe = 1'b1; m0_ad = 1'b0;
    run_to(305);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_lit("rst_mid_gnt", {5'd0, rd_gnt, busy, bus_oe}, 8'h00);
    check_lit("rst_mid_ctrl", {4'd0, bus_ad, bus_wr, bus_rd, bus_cs}, 8'h0F);
    run_to(100);
    check_lit("timer_restart_100", {7'd0, refresh_start}, 8'h00);
    run_to(101);
    check_lit("timer_restart_101", {7'd0, refresh_start}, 8'h01);

    // Randomized traffic, including stray and cross-master done pulses.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) wr_req = ~wr_req;
      rd_done = ($urandom_range(0, 19) == 0);
      wr_done = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 999) == 0);
      {m0_ad, m0_wr, m0_rd, m0_cs, m0_oe} = 5'($urandom);
      {m1_ad, m1_wr, m1_rd, m1_cs, m1_oe} = 5'($urandom);
      m0_dout = 8'($urandom);
      m1_dout = 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Arbitrates the shared multiplexed RTC address/data bus (ad, wr, rd, cs, 8-bit AD) between the periodic register reader (master 0) and the configuration writer (master 1). An internal refresh timer schedules reader sweeps, and the block inserts idle gaps between owners. It drives the single physical bus through a registered output mux. It sits between the two bus masters and the RTC pads.

## Interface
- REFRESH_CYCLES, 1000000: clock cycles between refresh requests (10 ms at 100 MHz); minimum 2.
- GAP_CYCLES, 4: idle bus cycles after every release; minimum 1.
- TIMEOUT_CYCLES, 1024: maximum grant duration before forced release (only with the timeout feature).

- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- wr_req  in  1  writer requests bus (level)
- wr_gnt  out  1  writer owns bus
- wr_done  in  1  writer transaction finished (1-cycle pulse)
- rd_gnt  out  1  reader owns bus
- rd_done  in  1  reader sweep finished (1-cycle pulse)
- refresh_start  out  1  1-cycle pulse that starts a reader sweep
- m0_ad, m0_wr, m0_rd, m0_cs  in  1 each  reader bus controls
- m0_dout  in  8  reader AD drive value
- m0_oe  in  1  reader AD drive enable
- m1_ad, m1_wr, m1_rd, m1_cs, m1_dout[7:0], m1_oe  in  writer equivalents
- bus_ad, bus_wr, bus_rd, bus_cs  out  1 each  to RTC
- bus_dout  out  8  AD drive value
- bus_oe  out  1  AD tristate enable (pad drives AD only when 1)
- busy  out  1  state is not IDLE
- timeout_err  out  1  1-cycle pulse on forced release

## Operation
- States: IDLE, GNT_RD, GNT_WR, GAP.
- Refresh timer: free-running from 0 to REFRESH_CYCLES-1, then wraps. At the terminal count it sets refresh_pend. A terminal count while refresh_pend is already set merges into the existing request.
- refresh_pend clears on entry to GNT_RD.
- Arbitration in IDLE:
  - If only one request is present, that master is granted.
  - If both are present, the writer wins unless last_owner == writer, in which case the reader wins. This alternates and prevents starvation.
- last_owner updates on each grant. Its reset value is reader.
- IDLE→GNT_RD: rd_gnt=1, and refresh_start pulses in the same cycle as entry.
- IDLE→GNT_WR: wr_gnt=1.
- GNT_x→GAP: on the corresponding done pulse. The grant drops on GAP entry.
- Dropping wr_req during GNT_WR has no effect; the grant holds until wr_done.
- GAP: lasts GAP_CYCLES cycles, then returns to IDLE.
- A done pulse from the non-owning master, or any done pulse outside a grant, is ignored.
- Bus mux:
  - Owner's m*_ signals are registered to bus_*.
  - In IDLE and GAP the bus is idle: ad=wr=rd=cs=1, dout=0x00, oe=0.
- Reset:
  - All grants 0, refresh_start 0, busy 0, timeout_err 0.
  - Bus idle, timer 0, refresh_pend 0, state IDLE.
  - Reset asserted mid-grant aborts the transaction immediately; the bus is idle on the next edge.

## Timing
- A request sampled in IDLE at edge N gives a grant visible after edge N+1.
- Bus output latency: one cycle from m*_ inputs.
- done sampled at edge M: grant low after M+1. Bus idle from M+1.
- IDLE is re-entered after M+1+GAP_CYCLES, and a new grant is possible one edge later.
- First refresh_pend is set REFRESH_CYCLES cycles after reset release.
- Back-to-back requests have a minimum turnaround of GAP_CYCLES+2 cycles between grants.

## Configuration
- RTC_ARB_TIMEOUT_EN defined:
  - A grant-duration counter clears on each grant.
  - When it reaches TIMEOUT_CYCLES without a done pulse, the grant drops, timeout_err pulses 1 cycle, and the FSM enters GAP.
  - If done and timeout occur in the same cycle, done wins and there is no error.
- RTC_ARB_TIMEOUT_EN undefined:
  - There is no counter; the grant holds until done.
  - timeout_err is tied 0.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum;
  - idle bus constants (BUS_IDLE_CTRL=4'b1111, BUS_IDLE_DATA=8'h00);
  - master index constants (MST_RD=0, MST_WR=1).
- Sub-module rtc_refresh_timer: parameter REFRESH_CYCLES, output tick (1-cycle pulse). The arbiter owns refresh_pend.

## Test plan
- REFRESH_CYCLES=100, no wr_req → refresh_start at cycle 101 after reset, rd_gnt high at 101; rd_done at 150 → rd_gnt low at 151, busy low at 151+GAP_CYCLES.
- wr_req and refresh_pend together with last_owner=reader → wr_gnt first. After wr_done, reader is granted even though wr_req is still held high.
- During GNT_WR drive m1_dout=0x26, m1_oe=1 → bus_dout=0x26, bus_oe=1 one cycle later. m0_* changes are not visible on the bus.
- Timeout feature enabled, TIMEOUT_CYCLES=16, grant with no done → timeout_err pulse 16 cycles after grant, grant low, bus idle. With the feature disabled, the grant holds indefinitely.
- Reset asserted at the 5th cycle of GNT_RD → next edge: rd_gnt=0, bus ad/wr/rd/cs=1, oe=0, state IDLE, refresh timer at 0.
- Stray rd_done in IDLE and wr_done during GNT_RD → no state change.
